// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined FP add/sub (exc|sign|exp|frac, no subnormals).
// Ports: X,Y,sub,in_tag via in_valid/in_ready; R,out_tag via out_valid/out_ready.
module fp_add_pipe #(
  parameter int WE    = 5,
  parameter int WF    = 6,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF+2:0] X,
  input  logic [WE+WF+2:0] Y,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WE+WF+2:0] R,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N  = WE + WF + 3;
  localparam int MW = WF + 4;
  localparam int SW = WF + 5;
  localparam int AW = 2 * WF + 4;
  localparam int LW = $clog2(SW + 1);
  localparam int EW = WE + 2;
  localparam logic [WE:0]  COLL = (WE+1)'(WF + 3);
  localparam logic [N-1:0] QNAN = {2'b11, {(N-2){1'b0}}};

  logic w_adv;
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  // ---- S1: decode, swap, align ----
  logic [1:0]    w_xc, w_yc;
  logic          w_xs, w_ys, w_yse;
  logic [WE-1:0] w_xe, w_ye;
  logic [WF-1:0] w_xf, w_yf;
  assign {w_xc, w_xs, w_xe, w_xf} = X;
  assign {w_yc, w_ys, w_ye, w_yf} = Y;
  assign w_yse = w_ys ^ sub;

  logic         w_sp;
  logic [N-1:0] w_spr;
  always_comb begin
    w_sp  = 1'b1;
    w_spr = '0;
    if (w_xc == 2'b11 || w_yc == 2'b11)
      w_spr = QNAN;
    else if (w_xc == 2'b10 && w_yc == 2'b10 && w_xs != w_yse)
      w_spr = QNAN;
    else if (w_xc == 2'b10)
      w_spr = {2'b10, w_xs, {(N-3){1'b0}}};
    else if (w_yc == 2'b10)
      w_spr = {2'b10, w_yse, {(N-3){1'b0}}};
    else if (w_xc == 2'b00 && w_yc == 2'b00)
      w_spr = {2'b00, w_xs & w_yse, {(N-3){1'b0}}};
    else if (w_xc == 2'b00)
      w_spr = {2'b01, w_yse, w_ye, w_yf};
    else if (w_yc == 2'b00)
      w_spr = {2'b01, w_xs, w_xe, w_xf};
    else
      w_sp = 1'b0;
  end

  logic          w_swap, w_sa, w_sb;
  logic [WE-1:0] w_ea, w_eb, w_d;
  logic [WF-1:0] w_fa, w_fb;
  logic [AW-1:0] w_wide, w_sh;
  logic [MW-1:0] w_ma, w_mb;
  assign w_swap = {w_ye, w_yf} > {w_xe, w_xf};
  assign w_sa   = w_swap ? w_yse : w_xs;
  assign w_sb   = w_swap ? w_xs : w_yse;
  assign w_ea   = w_swap ? w_ye : w_xe;
  assign w_eb   = w_swap ? w_xe : w_ye;
  assign w_fa   = w_swap ? w_yf : w_xf;
  assign w_fb   = w_swap ? w_xf : w_yf;
  assign w_d    = w_ea - w_eb;
  assign w_wide = {1'b1, w_fb, {(WF+3){1'b0}}};
  assign w_sh   = w_wide >> w_d;
  assign w_ma   = {1'b1, w_fa, 3'b000};
  // Layout 1.f|G|R|S; a shift past R leaves only the sticky bit.
  assign w_mb   = ({1'b0, w_d} >= COLL) ? MW'(1)
                : {w_sh[AW-1:WF+1], |w_sh[WF:0]};

  logic             r1_v, r1_sp, r1_s, r1_op;
  logic [N-1:0]     r1_spr;
  logic [TAG_W-1:0] r1_tag;
  logic [WE-1:0]    r1_e;
  logic [MW-1:0]    r1_ma, r1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_sp  <= 1'b0;
      r1_s   <= 1'b0;
      r1_op  <= 1'b0;
      r1_spr <= '0;
      r1_tag <= '0;
      r1_e   <= '0;
      r1_ma  <= '0;
      r1_mb  <= '0;
    end else if (w_adv) begin
      r1_v   <= in_valid;
      r1_sp  <= w_sp;
      r1_s   <= w_sa;
      r1_op  <= w_sa ^ w_sb;
      r1_spr <= w_spr;
      r1_tag <= in_tag;
      r1_e   <= w_ea;
      r1_ma  <= w_ma;
      r1_mb  <= w_mb;
    end
  end

  // ---- S2: add/sub, leading zeros ----
  function automatic logic [LW-1:0] f_lzc(input logic [SW-1:0] v);
    f_lzc = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) f_lzc = LW'(SW - 1 - i);
  endfunction

  logic [SW-1:0] w_sum;
  assign w_sum = r1_op ? {1'b0, r1_ma} - {1'b0, r1_mb}
                       : {1'b0, r1_ma} + {1'b0, r1_mb};

  logic             r2_v, r2_sp, r2_s;
  logic [N-1:0]     r2_spr;
  logic [TAG_W-1:0] r2_tag;
  logic [WE-1:0]    r2_e;
  logic [SW-1:0]    r2_sum;
  logic [LW-1:0]    r2_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_sp  <= 1'b0;
      r2_s   <= 1'b0;
      r2_spr <= '0;
      r2_tag <= '0;
      r2_e   <= '0;
      r2_sum <= '0;
      r2_lz  <= '0;
    end else if (w_adv) begin
      r2_v   <= r1_v;
      r2_sp  <= r1_sp;
      r2_s   <= r1_s;
      r2_spr <= r1_spr;
      r2_tag <= r1_tag;
      r2_e   <= r1_e;
      r2_sum <= w_sum;
      r2_lz  <= f_lzc(w_sum);
    end
  end

  // ---- S3: normalise, round, pack ----
  logic [SW-1:0] w_n;
  logic [WF:0]   w_mant;
  logic [WF+1:0] w_mr;
  logic [WF-1:0] w_frac;
  logic [EW-1:0] w_e;
  logic          w_g, w_st, w_up, w_ovf, w_unf;
  logic [N-1:0]  w_res;

  // Shift so the MSB of the sum lands in the top bit; a carry-out
  // case is a zero shift, which is a right shift relative to 1.f.
  assign w_n    = r2_sum << r2_lz;
  assign w_mant = w_n[SW-1:4];
  assign w_g    = w_n[3];
  assign w_st   = |w_n[2:0];
  assign w_up   = w_g & (w_st | w_mant[0]);
  assign w_mr   = {1'b0, w_mant} + (WF+2)'(w_up);
  assign w_frac = w_mr[WF+1] ? w_mr[WF:1] : w_mr[WF-1:0];
  assign w_e    = EW'(r2_e) + EW'(1) - EW'(r2_lz) + EW'(w_mr[WF+1]);
  assign w_unf  = w_e[EW-1];
  assign w_ovf  = !w_e[EW-1] && (|w_e[EW-2:WE]);

  always_comb begin
    w_res = {2'b01, r2_s, w_e[WE-1:0], w_frac};
    if (r2_sp)
      w_res = r2_spr;
    else if (r2_sum == '0)
      w_res = '0;
    else if (w_ovf)
      w_res = {2'b10, r2_s, {(N-3){1'b0}}};
    else if (w_unf)
      w_res = {2'b00, r2_s, {(N-3){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      R         <= '0;
      out_tag   <= '0;
    end else if (w_adv) begin
      out_valid <= r2_v;
      if (r2_v) begin
        R       <= w_res;
        out_tag <= r2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed + random checks of fp_add_pipe (WE=5, WF=6)
// against an exact-integer reference model and a tag scoreboard.
module tb_fp_add_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] X;
  logic [13:0] Y;
  logic        sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] R;
  logic [3:0]  out_tag;

  fp_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .sub       (sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Exact value = (-1)^s * (64+f) * 2^(e-15-6); sum as integers, then round.
  function automatic logic [13:0] model(input logic [13:0] x,
                                        input logic [13:0] y,
                                        input logic s);
    logic [1:0] xc, yc;
    logic       xs, ys, sg;
    int         xe, ye, xf, yf, p, e, sh;
    longint     a, b, sm, mag, q, rem, half;
    xc = x[13:12]; xs = x[11];
    yc = y[13:12]; ys = y[11] ^ s;
    xe = int'(x[10:6]); xf = int'(x[5:0]);
    ye = int'(y[10:6]); yf = int'(y[5:0]);
    if (xc == 2'b11 || yc == 2'b11) return 14'h3000;
    if (xc == 2'b10 && yc == 2'b10)
      return (xs == ys) ? {2'b10, xs, 11'd0} : 14'h3000;
    if (xc == 2'b10) return {2'b10, xs, 11'd0};
    if (yc == 2'b10) return {2'b10, ys, 11'd0};
    if (xc == 2'b00 && yc == 2'b00) return {2'b00, xs & ys, 11'd0};
    if (xc == 2'b00) return {2'b01, ys, y[10:0]};
    if (yc == 2'b00) return {2'b01, xs, x[10:0]};
    a = longint'(64 + xf) << xe;
    b = longint'(64 + yf) << ye;
    if (xs) a = -a;
    if (ys) b = -b;
    sm = a + b;
    if (sm == 0) return 14'h0000;
    sg  = sm < 0;
    mag = sg ? -sm : sm;
    p = 63;
    while (p > 0 && !mag[p]) p--;
    e = p - 6;
    if (p > 6) begin
      sh   = p - 6;
      q    = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 128) begin
        q = 64;
        e++;
      end
    end else begin
      q = mag << (6 - p);
    end
    if (e > 31) return {2'b10, sg, 11'd0};
    if (e < 0)  return {2'b00, sg, 11'd0};
    return {2'b01, sg, 5'(e), 6'(q - 64)};
  endfunction

  typedef struct {
    logic [13:0] r;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  logic        prev_stall;
  logic [13:0] prev_r;
  logic [3:0]  prev_tag;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("R_hold", 32'(R), 32'(prev_r));
        chk("tag_hold", 32'(out_tag), 32'(prev_tag));
      end
      if (sb.size() == 0)
        chk("spurious_valid", 32'(out_valid), 0);
      if (out_valid && !out_ready)
        chk("in_ready_stall", 32'(in_ready), 0);
      if (out_valid && out_ready && sb.size() > 0) begin
        chk("R", 32'(R), 32'(sb[0].r));
        chk("out_tag", 32'(out_tag), 32'(sb[0].tag));
        void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back('{model(X, Y, sub), in_tag});
        chk("inflight", 32'(sb.size() <= 3), 1);
      end
      prev_stall <= out_valid && !out_ready;
      prev_r     <= R;
      prev_tag   <= out_tag;
    end
  end

  function automatic logic [13:0] rnd_op();
    logic [13:0] v;
    v = 14'($urandom);
    if ($urandom_range(0, 15) < 12) v[13:12] = 2'b01;
    return v;
  endfunction

  task automatic one_op(input string nm, input logic [13:0] x,
                        input logic [13:0] y, input logic s,
                        input logic [3:0] t, input logic [13:0] want);
    int n;
    @(posedge clk); #1;
    X = x; Y = y; sub = s; in_tag = t;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 3);
    chk(nm, 32'(R), 32'(want));
    chk({nm, "_tag"}, 32'(out_tag), 32'(t));
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("drain", 32'(sb.size()), 0);
  endtask

  initial begin
    int sent;
    int seen;
    int n;
    rst_n = 1'b1; in_valid = 1'b0; X = '0; Y = '0;
    sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_R", 32'(R), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    one_op("one_plus_one", 14'h13C0, 14'h13C0, 1'b0, 4'd5, 14'h1400);
    one_op("cancel",       14'h13C0, 14'h13C0, 1'b1, 4'd6, 14'h0000);
    one_op("inf_m_inf",    14'h2000, 14'h2800, 1'b0, 4'd7, 14'h3000);
    one_op("tie_even",     14'h13C0, 14'h1200, 1'b0, 4'd8, 14'h13C0);
    one_op("tie_up",       14'h13C1, 14'h1200, 1'b0, 4'd9, 14'h13C2);
    one_op("ovf_pos",      14'h17FF, 14'h17FF, 1'b0, 4'd1, 14'h2000);
    one_op("ovf_neg",      14'h1FFF, 14'h1FFF, 1'b0, 4'd2, 14'h2800);
    one_op("unf_neg",      14'h1040, 14'h1041, 1'b1, 4'd3, 14'h0800);
    one_op("collapse_sub", 14'h13C0, 14'h1000, 1'b1, 4'd4, 14'h13C0);
    one_op("zero_norm",    14'h0000, 14'h1A45, 1'b1, 4'hA, 14'h1245);
    one_op("nan_in",       14'h3FFF, 14'h13C0, 1'b0, 4'hB, 14'h3000);
    one_op("neg_zeros",    14'h0800, 14'h0800, 1'b0, 4'hC, 14'h0800);
    one_op("inf_sub_inf",  14'h2000, 14'h2800, 1'b1, 4'hD, 14'h2000);
    drain();

    // Back-to-back with a 5-cycle output stall.
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = sent < 6;
      X = rnd_op(); Y = rnd_op();
      X[13:12] = 2'b01; Y[13:12] = 2'b01;
      sub = 1'($urandom);
      in_tag = 4'(sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    chk("stall_sent", 32'(sent), 6);
    drain();

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 3) != 0;
      in_valid  = $urandom_range(0, 4) != 0;
      X = rnd_op();
      case ($urandom_range(0, 3))
        0: Y = X ^ 14'($urandom_range(0, 3));
        1: begin
          Y = rnd_op();
          Y[10:6] = X[10:6] + 5'($urandom_range(0, 2));
        end
        default: Y = rnd_op();
      endcase
      sub    = 1'($urandom);
      in_tag = 4'($urandom);
    end
    drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    @(posedge clk); #1;
    X = 14'h13C0; Y = 14'h13C1; sub = 1'b0; in_tag = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    X = 14'h1400; Y = 14'h13C0; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_R", 32'(R), 0);
    chk("midrst_out_tag", 32'(out_tag), 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_replay", 32'(seen), 0);
    one_op("post_rst", 14'h13C0, 14'h13C0, 1'b0, 4'hE, 14'h1400);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
